pipe_valid_tracker: RTL
=======================

Name: pipe_valid_tracker

Overview:
- Consumer end of the hazard unit's stall/flush interface.
- Owns the per-stage valid bits and destination/load/store tags for ID, EX, MEM and WB.
- Applies stop_* and set_invalid_* each cycle.
- Returns the stage-invalid flags, stage rd and load/store flags that the hazard unit consumes.
- Also keeps a pipeline-state FSM and saturating performance counters for the CSR file.

Parameters:
- CNT_W, 32, width of each saturating performance counter.
- REG_W, 5, register index width.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset: state is cleared at a rising clk edge while reset==0.
- if_valid  input  1  IF holds a fetched instruction this cycle.
- if_rd  input  REG_W  rd decoded from the fetched instruction.
- if_is_load  input  1  fetched instruction is a load.
- if_is_store  input  1  fetched instruction is a store.
- stop_IF  input  1  IF stalled; no new instruction enters ID.
- stop_ID  input  1  ID stalled; ID holds, bubble enters EX.
- set_invalid_ID  input  1  kill the instruction in ID.
- set_invalid_EX  input  1  kill the instruction in EX.
- set_invalid_MEM  input  1  kill the instruction in MEM.
- EX_invalid  output  1  ~valid of EX.
- MEM_invalid  output  1  ~valid of MEM.
- WB_invalid  output  1  ~valid of WB.
- EX_rd  output  REG_W  rd in EX; 0 when EX is invalid.
- MEM_rd  output  REG_W  rd in MEM; 0 when MEM is invalid.
- WB_rd  output  REG_W  rd in WB; 0 when WB is invalid.
- is_load_EX  output  1  valid load in EX.
- is_store_EX  output  1  valid store in EX.
- is_load_MEM  output  1  valid load in MEM.
- pipe_state  output  2  FSM state code.
- retired_cnt  output  CNT_W  instructions leaving WB valid.
- stall_cnt  output  CNT_W  cycles with stop_ID=1.
- flush_cnt  output  CNT_W  flush events.

Behaviour:
- Reset (reset==0 at a rising edge):
  - all valid bits 0, so every *_invalid output is 1;
  - all rd 0, load/store flags 0;
  - counters 0; pipe_state=EMPTY.
  - Reset dominates every other input.
- Kill masks, combinational: kID=set_invalid_ID, kEX=set_invalid_EX, kMEM=set_invalid_MEM.
- Per rising edge, priority kill > stall > advance:
  - ID: if kID, ID_v<=0. Else if stop_ID, ID holds. Else if stop_IF, ID_v<=0 (bubble). Else ID_v<=if_valid and tags<=if_*.
  - EX: EX_v<=ID_v & ~kID & ~stop_ID; tags copied from ID.
  - MEM: MEM_v<=EX_v & ~kEX; tags copied from EX.
  - WB: WB_v<=MEM_v & ~kMEM; tags copied from MEM.
- Stall while kill is active: the kill wins. The ID contents are dropped, not held.
- Output gating: every rd/load/store output is ANDed with its stage valid, so an invalid stage never reports a nonzero rd.
- Latency: one cycle per stage; an instruction accepted into ID at edge N reaches WB at edge N+3 absent stalls and kills.
- FSM, updated at each rising edge:
  - EMPTY(0) -> RUN(1) when any stage valid bit becomes 1.
  - RUN -> STALL(2) when stop_ID=1 and no kill. STALL -> RUN when stop_ID=0.
  - Any state -> FLUSH(3) when any kill is asserted.
  - FLUSH -> EMPTY if all valid bits are 0 after the edge, else -> RUN.
  - RUN/STALL -> EMPTY when all valid bits are 0 and if_valid=0.
- Counters:
  - retired_cnt increments when WB_v=1.
  - stall_cnt increments when stop_ID=1 and no kill.
  - flush_cnt increments once per cycle in which any kill is 1.
  - All counters saturate at 2^CNT_W-1 and never wrap.
- Reset mid-stall or mid-flush: same as a cold reset; no pending kill or stall survives it.

Decomposition:
- Shared package cpu_pipe_pkg:
  - pipe_state codes EMPTY/RUN/STALL/FLUSH;
  - REG_W;
  - the stage tag bundle (valid, rd, is_load, is_store).
- Sub-module sat_counter(CNT_W): enable input, synchronous active-low clear. Instantiated three times.

Test Plan:
- Reset: hold reset=0 for 2 cycles with if_valid=1 -> EX/MEM/WB_invalid=1, all rd=0, counters=0, pipe_state=0.
- Flow: release reset, feed rd=5,6,7 on consecutive cycles -> EX_rd=5 one edge after ID capture; WB_rd=7 three edges after rd=7 enters ID; retired_cnt=3 after the drain; pipe_state goes 0->1->0.
- Load-use stall: load rd=3 in ID, stop_IF=stop_ID=1 for 1 cycle ->
  - EX_invalid=1 for that slot; ID keeps its instruction;
  - is_load_EX=1 then is_load_MEM=1;
  - stall_cnt=1; pipe_state=2 for one cycle.
- Branch flush: full pipe (rd 1..4), pulse set_invalid_ID/EX/MEM=1 for one cycle ->
  - next edge: EX/MEM/WB_invalid=1 and ID_v=0;
  - flush_cnt=1; pipe_state=3 then 0;
  - the instruction already in WB still retires (retired_cnt+1).
- Kill plus stall together: stop_ID=1 and set_invalid_ID=1 -> ID dropped, stall_cnt unchanged, flush_cnt+1.
- Saturation: CNT_W=3, 10 valid retirements -> retired_cnt=7 and stays 7.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the pipeline valid/tag tracker.
// Contents:
//   REG_W        - register index width
//   pipe_state_t - pipeline-state FSM codes (EMPTY/RUN/STALL/FLUSH)
//   stage_tag_t  - per-stage bundle: valid bit, rd, load and store flags
//   gated_rd     - rd of a stage, forced to zero when the stage is invalid
package cpu_pipe_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        FLUSH = 2'd3
    } pipe_state_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             is_load;
        logic             is_store;
    } stage_tag_t;

    // Consumers must never see a stale rd from a bubble.
    function automatic logic [REG_W-1:0] gated_rd(input stage_tag_t tag);
        return tag.valid ? tag.rd : '0;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for the performance counters.
// Ports:
//   clk     - clock, counter updates on rising edge
//   clear_n - synchronous active-low clear (dominates enable)
//   enable  - count this cycle
//   count   - current value, holds at all-ones instead of wrapping
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             enable,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_valid_tracker.sv
// Consumer end of the hazard unit's stall/flush interface.
// Tracks valid bits and rd/load/store tags for ID, EX, MEM and WB, applies
// the hazard unit's stop_* and set_invalid_* each cycle, and reports the
// stage-invalid flags, gated rd values and load/store flags back to it.
// Also keeps a pipeline-state FSM and three saturating perf counters.
// Ports:
//   clk, reset                 - clock; synchronous active-low reset
//   if_valid/if_rd/if_is_*     - instruction arriving from IF
//   stop_IF, stop_ID           - stall requests
//   set_invalid_ID/EX/MEM      - kill requests
//   *_invalid, *_rd, is_*      - per-stage status (rd/flags gated by valid)
//   pipe_state                 - FSM code (EMPTY/RUN/STALL/FLUSH)
//   retired_cnt/stall_cnt/flush_cnt - saturating performance counters
module pipe_valid_tracker
    import cpu_pipe_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int REG_W = cpu_pipe_pkg::REG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_valid,
    input  logic [REG_W-1:0] if_rd,
    input  logic             if_is_load,
    input  logic             if_is_store,
    input  logic             stop_IF,
    input  logic             stop_ID,
    input  logic             set_invalid_ID,
    input  logic             set_invalid_EX,
    input  logic             set_invalid_MEM,
    output logic             EX_invalid,
    output logic             MEM_invalid,
    output logic             WB_invalid,
    output logic [REG_W-1:0] EX_rd,
    output logic [REG_W-1:0] MEM_rd,
    output logic [REG_W-1:0] WB_rd,
    output logic             is_load_EX,
    output logic             is_store_EX,
    output logic             is_load_MEM,
    output logic [1:0]       pipe_state,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    stage_tag_t  id_q, ex_q, mem_q, wb_q;
    stage_tag_t  id_d, ex_d, mem_d, wb_d;
    pipe_state_t state_q, state_d;

    logic kill_id, kill_ex, kill_mem, any_kill;
    logic any_valid_next;
    logic stall_event;

    assign kill_id  = set_invalid_ID;
    assign kill_ex  = set_invalid_EX;
    assign kill_mem = set_invalid_MEM;
    assign any_kill = kill_id | kill_ex | kill_mem;

    // A stall that coincides with a kill is not a stall: the kill drops ID.
    assign stall_event = stop_ID & ~any_kill;

    // Next stage contents. Priority per stage is kill > stall > advance;
    // tags travel with the instruction, only the valid bit is masked.
    always_comb begin
        id_d = id_q;
        if (kill_id) begin
            id_d.valid = 1'b0;
        end else if (stop_ID) begin
            id_d = id_q;
        end else if (stop_IF) begin
            id_d.valid = 1'b0;
        end else begin
            id_d.valid    = if_valid;
            id_d.rd       = if_rd;
            id_d.is_load  = if_is_load;
            id_d.is_store = if_is_store;
        end

        ex_d        = id_q;
        ex_d.valid  = id_q.valid & ~kill_id & ~stop_ID;

        mem_d       = ex_q;
        mem_d.valid = ex_q.valid & ~kill_ex;

        wb_d        = mem_q;
        wb_d.valid  = mem_q.valid & ~kill_mem;
    end

    assign any_valid_next = id_d.valid | ex_d.valid | mem_d.valid | wb_d.valid;

    // Stage registers and FSM state; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (!reset) begin
            id_q    <= '0;
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            state_q <= EMPTY;
        end else begin
            id_q    <= id_d;
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            state_q <= state_d;
        end
    end

    // FSM decisions look at the valid bits as they will be after the edge,
    // so the state always describes the pipeline it is reported alongside.
    always_comb begin
        state_d = state_q;
        if (any_kill) begin
            state_d = FLUSH;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (any_valid_next) begin
                        state_d = RUN;
                    end
                end
                RUN, STALL: begin
                    if (!any_valid_next && !if_valid) begin
                        state_d = EMPTY;
                    end else if (stop_ID) begin
                        state_d = STALL;
                    end else begin
                        state_d = RUN;
                    end
                end
                FLUSH: begin
                    state_d = any_valid_next ? RUN : EMPTY;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    assign pipe_state  = state_q;

    assign EX_invalid  = ~ex_q.valid;
    assign MEM_invalid = ~mem_q.valid;
    assign WB_invalid  = ~wb_q.valid;

    assign EX_rd       = gated_rd(ex_q);
    assign MEM_rd      = gated_rd(mem_q);
    assign WB_rd       = gated_rd(wb_q);

    assign is_load_EX  = ex_q.valid & ex_q.is_load;
    assign is_store_EX = ex_q.valid & ex_q.is_store;
    assign is_load_MEM = mem_q.valid & mem_q.is_load;

    sat_counter #(.CNT_W(CNT_W)) u_retired_cnt (
        .clk     (clk),
        .clear_n (reset),
        .enable  (wb_q.valid),
        .count   (retired_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .clear_n (reset),
        .enable  (stall_event),
        .count   (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .clear_n (reset),
        .enable  (any_kill),
        .count   (flush_cnt)
    );

endmodule
